// File: rtl/registrador_acumulador.sv
// Accumulator register that drives an external adder-subtractor. It accepts
// LDA/ADD/SUB/OUT commands and returns results on a valid/ready output channel.
// Optional feature macro: FLAG_OVERFLOW_EN adds the Flag_Overflow output.
module registrador_acumulador (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       Cmd_Valido,
  input  logic [1:0] Cmd_Op,
  input  logic [7:0] Cmd_Dado,
  output logic       Cmd_Pronto,
  output logic [7:0] A_Ula,
  output logic [7:0] B_Ula,
  output logic       Subtrair,
  output logic       Cin,
  input  logic [8:0] S_Ula,
  input  logic       Cout_Ula,
  output logic [7:0] Saida,
  output logic       Saida_Valida,
  input  logic       Saida_Pronto,
  output logic       Flag_Carry,
`ifdef FLAG_OVERFLOW_EN
  output logic       Flag_Overflow,
`endif
  output logic       Flag_Zero
);

  localparam int unsigned W_DADO = 8;

  localparam logic [1:0] OP_LDA = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  typedef enum logic [0:0] {
    OCIOSO  = 1'b0,
    EXECUTA = 1'b1
  } estado_t;

  estado_t             estado;
  estado_t             estado_prox;
  logic [W_DADO-1:0]   acumulador;
  logic [W_DADO-1:0]   reg_b;
  logic                op_sub;
  logic                aceita_c;

  // The adder carry arrives on Cout_Ula, so the top bit of S_Ula is not needed.
  logic                unused_s_ula_msb;
  assign unused_s_ula_msb = S_Ula[8];

  assign aceita_c = Cmd_Valido && Cmd_Pronto;

  // State register; CLR wins over EXECUTA completion
  always_ff @(posedge CLK) begin
    if (CLR) begin
      estado <= OCIOSO;
    end else begin
      estado <= estado_prox;
    end
  end

  // Next state: ADD/SUB spend exactly one cycle in EXECUTA
  always_comb begin
    estado_prox = estado;
    unique case (estado)
      OCIOSO: begin
        if (aceita_c && (Cmd_Op == OP_ADD || Cmd_Op == OP_SUB)) begin
          estado_prox = EXECUTA;
        end
      end
      EXECUTA: estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  // Outputs decoded from state: handshake and adder controls
  always_comb begin
    Cmd_Pronto = 1'b0;
    A_Ula      = acumulador;
    B_Ula      = reg_b;
    Subtrair   = 1'b0;
    Cin        = 1'b0;
    unique case (estado)
      OCIOSO: begin
        Cmd_Pronto = !Saida_Valida;
      end
      EXECUTA: begin
        Subtrair = op_sub;
        Cin      = op_sub;
      end
      default: begin
        Cmd_Pronto = 1'b0;
      end
    endcase
  end

`ifdef FLAG_OVERFLOW_EN
  logic [W_DADO-1:0] b_efetivo_c;
  logic              overflow_c;

  // Signed overflow: operands share a sign after B inversion, result sign differs
  assign b_efetivo_c = Subtrair ? ~B_Ula : B_Ula;
  assign overflow_c  = (A_Ula[W_DADO-1] == b_efetivo_c[W_DADO-1]) &&
                       (S_Ula[W_DADO-1] != A_Ula[W_DADO-1]);

  always_ff @(posedge CLK) begin
    if (CLR) begin
      Flag_Overflow <= 1'b0;
    end else if (estado == EXECUTA) begin
      Flag_Overflow <= overflow_c;
    end
  end
`endif

  // Datapath: command capture, result write-back and output channel.
  // Accepts only happen in OCIOSO with the output channel empty, so they never
  // collide with write-back or with the Saida_Valida clear.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      acumulador   <= '0;
      reg_b        <= '0;
      op_sub       <= 1'b0;
      Saida        <= '0;
      Saida_Valida <= 1'b0;
      Flag_Carry   <= 1'b0;
      Flag_Zero    <= 1'b0;
    end else begin
      if (aceita_c) begin
        unique case (Cmd_Op)
          OP_LDA: acumulador <= Cmd_Dado;
          OP_ADD: begin
            reg_b  <= Cmd_Dado;
            op_sub <= 1'b0;
          end
          OP_SUB: begin
            reg_b  <= Cmd_Dado;
            op_sub <= 1'b1;
          end
          OP_OUT: begin
            Saida        <= acumulador;
            Saida_Valida <= 1'b1;
          end
          default: acumulador <= acumulador;
        endcase
      end
      if (estado == EXECUTA) begin
        acumulador <= S_Ula[W_DADO-1:0];
        Flag_Carry <= Cout_Ula;
        Flag_Zero  <= (S_Ula[W_DADO-1:0] == W_DADO'(0));
      end
      if (Saida_Valida && Saida_Pronto) begin
        Saida_Valida <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_registrador_acumulador.sv
// Bench for registrador_acumulador: directed scenarios plus random commands
// against an arithmetic reference model. The external adder is modelled here.
module tb_registrador_acumulador;

  localparam logic [1:0] LDA = 2'b00;
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] SUB = 2'b10;
  localparam logic [1:0] OUT = 2'b11;

  logic       CLK;
  logic       CLR;
  logic       Cmd_Valido;
  logic [1:0] Cmd_Op;
  logic [7:0] Cmd_Dado;
  logic       Cmd_Pronto;
  logic [7:0] A_Ula;
  logic [7:0] B_Ula;
  logic       Subtrair;
  logic       Cin;
  logic [8:0] S_Ula;
  logic       Cout_Ula;
  logic [7:0] Saida;
  logic       Saida_Valida;
  logic       Saida_Pronto;
  logic       Flag_Carry;
  logic       Flag_Zero;
`ifdef FLAG_OVERFLOW_EN
  logic       Flag_Overflow;
`endif

  registrador_acumulador dut (
    .CLK          (CLK),
    .CLR          (CLR),
    .Cmd_Valido   (Cmd_Valido),
    .Cmd_Op       (Cmd_Op),
    .Cmd_Dado     (Cmd_Dado),
    .Cmd_Pronto   (Cmd_Pronto),
    .A_Ula        (A_Ula),
    .B_Ula        (B_Ula),
    .Subtrair     (Subtrair),
    .Cin          (Cin),
    .S_Ula        (S_Ula),
    .Cout_Ula     (Cout_Ula),
    .Saida        (Saida),
    .Saida_Valida (Saida_Valida),
    .Saida_Pronto (Saida_Pronto),
    .Flag_Carry   (Flag_Carry),
`ifdef FLAG_OVERFLOW_EN
    .Flag_Overflow(Flag_Overflow),
`endif
    .Flag_Zero    (Flag_Zero)
  );

  // Downstream adder-subtractor
  logic [8:0] soma;
  assign soma     = {1'b0, A_Ula} + {1'b0, (Subtrair ? ~B_Ula : B_Ula)} + 9'(Cin);
  assign S_Ula    = soma;
  assign Cout_Ula = soma[8];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0] m_acc, m_b, m_saida;
  logic       m_c, m_z, m_sv;
`ifdef FLAG_OVERFLOW_EN
  logic       m_v;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_acc = 8'h00; m_b = 8'h00; m_saida = 8'h00;
    m_c = 1'b0; m_z = 1'b0; m_sv = 1'b0;
`ifdef FLAG_OVERFLOW_EN
    m_v = 1'b0;
`endif
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".acc"},    32'(A_Ula),        32'(m_acc));
    chk({tag, ".regb"},   32'(B_Ula),        32'(m_b));
    chk({tag, ".carry"},  32'(Flag_Carry),   32'(m_c));
    chk({tag, ".zero"},   32'(Flag_Zero),    32'(m_z));
    chk({tag, ".svalid"}, 32'(Saida_Valida), 32'(m_sv));
    chk({tag, ".saida"},  32'(Saida),        32'(m_saida));
    chk({tag, ".pronto"}, 32'(Cmd_Pronto),   32'(!m_sv));
    chk({tag, ".sub"},    32'({Subtrair, Cin}), 32'(0));
`ifdef FLAG_OVERFLOW_EN
    chk({tag, ".ovf"},    32'(Flag_Overflow), 32'(m_v));
`endif
  endtask

  task automatic do_reset(input string tag);
    Cmd_Valido = 1'b0;
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    model_reset();
    check_state(tag);
  endtask

  // Offer one command, wait for acceptance, then follow it through completion
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [7:0] d);
    int n;
    int sa, sd, r;
    logic sub;
    Cmd_Valido = 1'b1;
    Cmd_Op     = op;
    Cmd_Dado   = d;
    n = 0;
    while (!Cmd_Pronto && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      chk({tag, ".accept_timeout"}, 32'(Cmd_Pronto), 32'(1));
      Cmd_Valido = 1'b0;
      return;
    end
    tick();
    Cmd_Valido = 1'b0;
    Cmd_Dado   = 8'($urandom);
    case (op)
      LDA: m_acc = d;
      ADD, SUB: begin
        sub = (op == SUB);
        m_b = d;
        chk({tag, ".exec_pronto"}, 32'(Cmd_Pronto), 32'(0));
        chk({tag, ".exec_sub"},    32'(Subtrair),   32'(sub));
        chk({tag, ".exec_cin"},    32'(Cin),        32'(sub));
        chk({tag, ".exec_a"},      32'(A_Ula),      32'(m_acc));
        chk({tag, ".exec_b"},      32'(B_Ula),      32'(d));
        sa = int'($signed(m_acc));
        sd = int'($signed(d));
        if (sub) begin
          r   = int'(m_acc) - int'(d);
          m_c = (m_acc >= d);
`ifdef FLAG_OVERFLOW_EN
          m_v = (sa - sd > 127) || (sa - sd < -128);
`endif
        end else begin
          r   = int'(m_acc) + int'(d);
          m_c = (r > 255);
`ifdef FLAG_OVERFLOW_EN
          m_v = (sa + sd > 127) || (sa + sd < -128);
`endif
        end
        m_acc = 8'(r);
        m_z   = (m_acc == 8'h00);
        tick();
      end
      default: begin
        m_saida = m_acc;
        m_sv    = 1'b1;
        chk({tag, ".out_valid"}, 32'(Saida_Valida), 32'(1));
        chk({tag, ".out_data"},  32'(Saida),        32'(m_saida));
        if (Saida_Pronto) begin
          tick();
          m_sv = 1'b0;
        end
      end
    endcase
    check_state(tag);
  endtask

  initial begin
    CLR = 1'b0; Cmd_Valido = 1'b0; Cmd_Op = LDA; Cmd_Dado = 8'h00; Saida_Pronto = 1'b0;
    model_reset();
    tick();
    do_reset("reset");

    // LDA 0x2C, ADD 0xD6, OUT
    Saida_Pronto = 1'b1;
    do_cmd("r27.lda", LDA, 8'h2C);
    do_cmd("r27.add", ADD, 8'hD6);
    do_cmd("r27.out", OUT, 8'h00);
    chk("r27.saida_value", 32'(Saida), 32'(8'h02));
    chk("r27.carry_value", 32'(Flag_Carry), 32'(1));

    // LDA 0xAD, SUB 0x6B
    do_cmd("r28.lda", LDA, 8'hAD);
    do_cmd("r28.sub", SUB, 8'h6B);
    chk("r28.acc_value", 32'(A_Ula), 32'(8'h42));

    // LDA 0x55, SUB 0x55
    do_cmd("r29.lda", LDA, 8'h55);
    do_cmd("r29.sub", SUB, 8'h55);
    chk("r29.zero_value", 32'(Flag_Zero), 32'(1));

    // Output backpressure holds off a pending LDA
    Saida_Pronto = 1'b0;
    do_cmd("r30.out", OUT, 8'h00);
    Cmd_Valido = 1'b1; Cmd_Op = LDA; Cmd_Dado = 8'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r30.hold_valid",  32'(Saida_Valida), 32'(1));
      chk("r30.hold_saida",  32'(Saida),        32'(m_saida));
      chk("r30.hold_pronto", 32'(Cmd_Pronto),   32'(0));
      chk("r30.hold_acc",    32'(A_Ula),        32'(m_acc));
    end
    Saida_Pronto = 1'b1;
    tick();
    Saida_Pronto = 1'b0;
    m_sv = 1'b0;
    chk("r30.release_valid",  32'(Saida_Valida), 32'(0));
    chk("r30.release_pronto", 32'(Cmd_Pronto),   32'(1));
    chk("r30.release_acc",    32'(A_Ula),        32'(m_acc));
    tick();
    Cmd_Valido = 1'b0;
    m_acc = 8'h99;
    check_state("r30.lda");

    // CLR during EXECUTA discards the result
    do_cmd("r31.lda", LDA, 8'h10);
    Cmd_Valido = 1'b1; Cmd_Op = ADD; Cmd_Dado = 8'h20;
    tick();
    Cmd_Valido = 1'b0;
    chk("r31.in_exec", 32'(Cmd_Pronto), 32'(0));
    do_reset("r31.after_clr");
    tick();
    check_state("r31.settled");

`ifdef FLAG_OVERFLOW_EN
    do_cmd("r32.lda", LDA, 8'h7F);
    do_cmd("r32.add", ADD, 8'h01);
    chk("r32.acc_value", 32'(A_Ula),         32'(8'h80));
    chk("r32.ovf_value", 32'(Flag_Overflow), 32'(1));
`endif

    // Random command stream
    Saida_Pronto = 1'b1;
    for (int i = 0; i < 60; i++) begin
      do_cmd("rand", 2'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
